// File: rtl/stream_muxn.sv
// N-channel valid/ready stream multiplexer with a single registered output stage.
// Define STREAM_MUXN_RR_EN for round-robin arbitration; default is fixed priority.
module stream_muxn #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4,
  localparam int unsigned SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  input  logic                 out_ready
);

  logic             load;
  logic             any_grant;
  logic             xfer;
  logic [N-1:0]     grant;
  logic [SELW-1:0]  gnt_idx;
  logic [WIDTH-1:0] sel_data;

  assign load = !out_valid || out_ready;

`ifdef STREAM_MUXN_RR_EN
  logic [SELW-1:0] ptr_q, ptr_d;

  // Scan channels starting at the pointer, wrapping modulo N.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant     = '0;
    gnt_idx   = '0;
    any_grant = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!any_grant && in_valid[idx]) begin
        any_grant    = 1'b1;
        grant[idx]   = 1'b1;
        gnt_idx      = SELW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: lowest valid index wins.
  always_comb begin
    grant     = '0;
    gnt_idx   = '0;
    any_grant = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!any_grant && in_valid[i]) begin
        any_grant = 1'b1;
        grant[i]  = 1'b1;
        gnt_idx   = SELW'(i);
      end
    end
  end
`endif

  // rst_n gates ready so no channel sees an acceptance while reset is held.
  assign in_ready = grant & {N{load & rst_n}};
  assign xfer     = any_grant && load && rst_n;
  assign sel_data = in_data[gnt_idx*WIDTH +: WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_sel   <= gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/stream_muxn.md
STREAM_MUXN -- requirements
Module: stream_muxn

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of each channel and of the output.
REQ-002 SHALL have parameter N, default 4, number of input channels; legal range 1..16.
REQ-003 SHALL derive localparam SELW = max(1, ceil(log2(N))), the width of the channel index.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, N; bit i means channel i offers data.
REQ-007 SHALL have port in_data, input, N*WIDTH; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port in_ready, output, N; bit i means channel i's data is accepted this cycle.
REQ-009 SHALL have port out_valid, output, 1; the output register holds a valid item.
REQ-010 SHALL have port out_data, output, WIDTH; the registered selected data.
REQ-011 SHALL have port out_sel, output, SELW; the index of the channel that supplied out_data.
REQ-012 SHALL have port out_ready, input, 1; the downstream accepts out_data this cycle.

Function
REQ-013 SHALL transfer on channel i when in_valid[i] && in_ready[i], and on the output when out_valid && out_ready.
REQ-014 SHALL define load = !out_valid || out_ready (output register empty or draining).
REQ-015 SHALL assert at most one in_ready bit per cycle: in_ready[i] = load && grant[i].
REQ-016 SHALL compute grant combinationally from in_valid and arbitration state; grant is all-zero when in_valid is all-zero.
REQ-017 SHALL, on a channel transfer, register out_data <= channel data and out_sel <= i, with out_valid = 1 next cycle (latency 1 cycle).
REQ-018 SHALL clear out_valid next cycle when an output transfer occurs and no channel transfer occurs.
REQ-019 SHALL hold out_data and out_sel stable while out_valid && !out_ready.
REQ-020 SHALL sustain one item per cycle when out_ready stays high and any in_valid is set (simultaneous drain and load).
REQ-021 SHALL have in_ready depend combinationally on out_ready; out_valid, out_data and out_sel SHALL be purely registered.
REQ-022 SHALL leave a channel's in_valid/in_data unobserved while it is not granted; a channel that is not granted is never dropped, only delayed.

Reset
REQ-023 SHALL, while rst_n = 0, force out_valid = 0, out_data = 0, out_sel = 0, and arbitration pointer = 0, independent of clk.
REQ-024 SHALL drive in_ready = 0 on all channels while rst_n = 0.
REQ-025 SHALL discard any item held in the output register when reset asserts mid-operation; no transfer is reported for it.
REQ-026 SHALL, on the first edge after rst_n deasserts, be able to accept an item (out_valid = 0, so load = 1).

Configuration
REQ-027 SHALL compile round-robin arbitration when macro STREAM_MUXN_RR_EN is defined.
REQ-028 SHALL, with STREAM_MUXN_RR_EN, keep pointer ptr (SELW bits, reset 0) and grant the first valid channel at index ptr, ptr+1, ... wrapping modulo N.
REQ-029 SHALL, with STREAM_MUXN_RR_EN, set ptr <= (g+1) mod N after a channel transfer from channel g (N-1 wraps to 0) and leave ptr unchanged otherwise.
REQ-030 SHALL, without STREAM_MUXN_RR_EN, use fixed priority (lowest valid index wins) and contain no pointer register.

Verification (N=4, WIDTH=32)
REQ-031 SHALL check: reset, then in_valid=4'b0001, in_data ch0=32'hDEADBEEF, out_ready=1 -> in_ready=4'b0001; next cycle out_valid=1, out_data=32'hDEADBEEF, out_sel=0.
REQ-032 SHALL check: out_valid=1 with out_ready=0 for 3 cycles while ch2 is valid -> in_ready=0 throughout; out_data/out_sel unchanged; ch2 is accepted in the cycle out_ready rises.
REQ-033 SHALL check (RR_EN): in_valid=4'b1111 held, out_ready=1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles with out_valid continuously 1.
REQ-034 SHALL check (no RR_EN): in_valid=4'b1110 held, out_ready=1 -> out_sel=1 every cycle; channels 2 and 3 never get in_ready.
REQ-035 SHALL check (RR_EN): after a grant to channel 3, in_valid=4'b0101 -> channel 0 granted (ptr wrapped to 0), then channel 2.
REQ-036 SHALL check: rst_n pulled low while out_valid=1 and out_ready=0 -> out_valid=0, out_data=0, out_sel=0 immediately without a clock edge; the held item never appears at the output.
